// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
//   Control stage in front of an up/down counter. It drives the counter's
//   enable and direction and watches the count through counter_in. The count
//   sweeps up and down between LOW_LIMIT and HIGH_LIMIT and pauses for DWELL
//   cycles at each limit before reversing.
//
//   Optional build macro: SWEEP_SINGLE_SHOT_EN. When defined, the block does
//   one full sweep and then returns to IDLE at the end of the low dwell.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   start       in   pulse; begins sweeping from IDLE
//   stop        in   pulse; returns to IDLE from any state
//   counter_in  in   current counter value (feedback), WIDTH bits
//   enable      out  counter enable, high only in UP and DOWN
//   direction   out  counter direction, 1 = up, 0 = down (registered)
//   busy        out  high whenever the state is not IDLE
//   turn        out  one-cycle pulse on each reversal (registered)
//   sweep_count out  completed up+down sweeps, wraps at 255
module counter_sweep_ctrl #(
  parameter int WIDTH      = 8,
  parameter int LOW_LIMIT  = 0,
  parameter int HIGH_LIMIT = 30,
  parameter int DWELL      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] counter_in,
  output logic             enable,
  output logic             direction,
  output logic             busy,
  output logic             turn,
  output logic [7:0]       sweep_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    DWELL_HI = 3'd2,
    DOWN     = 3'd3,
    DWELL_LO = 3'd4
  } state_e;

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [WIDTH-1:0] HI_LIM     = WIDTH'(HIGH_LIMIT);
  // Leave UP/DOWN one count early: the counter still takes the step on the
  // transition edge, so it lands exactly on the limit as enable drops.
  localparam logic [WIDTH-1:0] HI_TRIG    = WIDTH'(HIGH_LIMIT - 1);
  localparam logic [WIDTH-1:0] LO_TRIG    = WIDTH'(LOW_LIMIT + 1);
  localparam logic [DCW-1:0]   DWELL_LAST = DCW'(DWELL - 1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic             turn_q, turn_d;
  logic [7:0]       sweep_q, sweep_d;
  logic [DCW-1:0]   dwell_q, dwell_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
      turn_q  <= 1'b0;
      sweep_q <= 8'd0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      turn_q  <= turn_d;
      sweep_q <= sweep_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    turn_d  = 1'b0;
    sweep_d = sweep_q;
    dwell_d = dwell_q;

    if (stop) begin
      // stop wins over everything; direction and sweep_count are kept
      state_d = IDLE;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dwell_d = '0;
            if (counter_in >= HI_LIM) begin
              state_d = DOWN;
              dir_d   = 1'b0;
            end else begin
              state_d = UP;
              dir_d   = 1'b1;
            end
          end
        end
        UP: begin
          // >= also catches feedback already past the limit: no wrap-around
          if (counter_in >= HI_TRIG) begin
            state_d = DWELL_HI;
            dwell_d = '0;
          end
        end
        DWELL_HI: begin
          if (dwell_q == DWELL_LAST) begin
            state_d = DOWN;
            dir_d   = 1'b0;
            turn_d  = 1'b1;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DCW'(1);
          end
        end
        DOWN: begin
          if (counter_in <= LO_TRIG) begin
            state_d = DWELL_LO;
            dwell_d = '0;
          end
        end
        DWELL_LO: begin
          if (dwell_q == DWELL_LAST) begin
`ifdef SWEEP_SINGLE_SHOT_EN
            state_d = IDLE;
`else
            state_d = UP;
`endif
            dir_d   = 1'b1;
            turn_d  = 1'b1;
            sweep_d = sweep_q + 8'd1;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DCW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          dwell_d = '0;
        end
      endcase
    end
  end

  assign enable      = (state_q == UP) || (state_q == DOWN);
  assign busy        = (state_q != IDLE);
  assign direction   = dir_q;
  assign turn        = turn_q;
  assign sweep_count = sweep_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a behavioural up/down counter closes the
// feedback loop, and a phase/countdown reference model predicts the outputs
// every cycle. Directed steps cover the documented scenarios, then random
// start/stop pulses, an asynchronous reset and a sweep_count wrap.
module tb_counter_sweep_ctrl;

  localparam int HI = 30;
  localparam int LO = 0;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop;
  logic [7:0] cnt;
  logic       enable, direction, busy, turn;
  logic [7:0] sweep_count;

  int checks = 0;
  int errors = 0;

  // reference model: phase 0 idle, 1 rising, 2 high dwell, 3 falling, 4 low dwell
  int   m_ph, m_rem, m_sw;
  logic m_dir, m_turn;

  counter_sweep_ctrl #(.WIDTH(8), .LOW_LIMIT(LO), .HIGH_LIMIT(HI), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .counter_in(cnt),
    .enable(enable), .direction(direction), .busy(busy), .turn(turn),
    .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_ph = 0; m_rem = 0; m_sw = 0; m_dir = 1'b1; m_turn = 1'b0;
  endtask

  // one clock of the reference model, from the inputs seen before the edge
  task automatic mstep(input logic s, input logic p, input int c);
    m_turn = 1'b0;
    if (p) begin
      m_ph = 0; m_rem = 0;
    end else if (m_ph == 0) begin
      if (s) begin
        m_ph  = (c >= HI) ? 3 : 1;
        m_dir = (c >= HI) ? 1'b0 : 1'b1;
      end
    end else if (m_ph == 1) begin
      if (c + 1 >= HI) begin m_ph = 2; m_rem = DW; end
    end else if (m_ph == 3) begin
      if (c - 1 <= LO) begin m_ph = 4; m_rem = DW; end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_turn = 1'b1;
        if (m_ph == 2) begin
          m_ph = 3; m_dir = 1'b0;
        end else begin
`ifdef SWEEP_SINGLE_SHOT_EN
          m_ph = 0;
`else
          m_ph = 1;
`endif
          m_dir = 1'b1;
          m_sw  = (m_sw + 1) % 256;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("enable",    enable,      (m_ph == 1 || m_ph == 3));
    chk("busy",      busy,        (m_ph != 0));
    chk("direction", direction,   m_dir);
    chk("turn",      turn,        m_turn);
    chk("sweeps",    sweep_count, m_sw);
  endtask

  // called #1 after a rising edge; advances one cycle and checks
  task automatic tick(input logic s, input logic p);
    logic en, dr;
    start = s; stop = p;
    en = enable; dr = direction;
    mstep(s, p, int'(cnt));
    @(posedge clk); #1;
    if (en) cnt = dr ? cnt + 8'd1 : cnt - 8'd1;
    start = 1'b0; stop = 1'b0;
    check_model();
  endtask

  task automatic run_until_turn(input int maxc, output int n);
    n = 0;
    do begin
      tick(1'b0, 1'b0);
      n++;
    end while (turn !== 1'b1 && n < maxc);
    chk("turn_seen", turn, 1'b1);
  endtask

  task automatic reset_checks();
    chk("rst_enable", enable, 0);
    chk("rst_dir",    direction, 1);
    chk("rst_busy",   busy, 0);
    chk("rst_turn",   turn, 0);
    chk("rst_sweeps", sweep_count, 0);
  endtask

  initial begin
    int n, n_lo, lo_turns, guard;
    logic s, p;
    rst = 1'b0; start = 1'b0; stop = 1'b0; cnt = 8'd0;
    mreset();
    @(negedge clk);
    reset_checks();
    rst = 1'b1;
    @(posedge clk); #1;

    // full sweep from 0
    tick(1'b1, 1'b0);
    chk("start_busy", busy, 1);
    chk("start_en",   enable, 1);
    run_until_turn(200, n);
    chk("hi_turn_lat", n, 34);
    chk("hi_cnt",      cnt, HI);
    chk("hi_dir",      direction, 0);
    run_until_turn(200, n_lo);
    chk("lo_turn_lat", n_lo, 34);
    chk("lo_sweeps",   sweep_count, 1);
    chk("lo_cnt",      cnt, LO);
`ifdef SWEEP_SINGLE_SHOT_EN
    chk("ss_busy", busy, 0);
    repeat (3) tick(1'b0, 1'b0);
    chk("ss_hold", cnt, LO);
    tick(1'b1, 1'b0);
    run_until_turn(200, n);
    chk("ss_hi2", n, 34);
`else
    chk("lo_busy", busy, 1);
    chk("lo_dir",  direction, 1);
    run_until_turn(200, n);
    chk("period", n_lo + n, 68);
`endif

    // stop in UP at 12, restart from 13
    tick(1'b0, 1'b1);
    chk("stop_busy", busy, 0);
    cnt = 8'd0;
    tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    chk("pre_stop_cnt", cnt, 12);
    tick(1'b0, 1'b1);
    chk("stop_cnt", cnt, 13);
    chk("stop_en",  enable, 0);
    repeat (3) tick(1'b0, 1'b0);
    chk("stop_hold", cnt, 13);
    tick(1'b1, 1'b0);
    run_until_turn(200, n);
    chk("resume_lat", n, 21);
    chk("resume_cnt", cnt, HI);

    // start+stop in IDLE, start during DOWN
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("ss_idle_busy", busy, 0);
    cnt = 8'd30;
    tick(1'b1, 1'b0);
    chk("hi_start_dir", direction, 0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("down_start_busy", busy, 1);
    chk("down_start_en",   enable, 1);
    chk("down_start_dir",  direction, 0);

    // out-of-range feedback in UP, and start from above the limit
    tick(1'b0, 1'b1);
    cnt = 8'd5;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    cnt = 8'd50;
    tick(1'b0, 1'b0);
    chk("oor_en", enable, 0);
    run_until_turn(20, n);
    chk("oor_dwell", n, DW);
    tick(1'b0, 1'b1);
    cnt = 8'd40;
    tick(1'b1, 1'b0);
    chk("above_dir", direction, 0);

    // random start/stop pulses
    tick(1'b0, 1'b1);
    cnt = 8'd0;
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom_range(0, 31) == 0);
      p = ($urandom_range(0, 96) == 0);
      tick(s, p);
    end

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1 reset_checks();
    mreset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // sweep_count wrap 255 -> 0
    cnt = 8'd0;
    lo_turns = 0;
    guard = 0;
    while (lo_turns < 256 && guard < 20000) begin
      tick(!busy, 1'b0);
      guard++;
      if (turn === 1'b1 && direction === 1'b1) begin
        lo_turns++;
        if (lo_turns == 255) chk("sweeps_255", sweep_count, 255);
      end
    end
    chk("wrap_turns",  lo_turns, 256);
    chk("wrap_sweeps", sweep_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Control stage directly upstream of the up/down counter.
- Drives the counter's enable and direction inputs and watches its count through a feedback input.
- Sweeps the count up and down between two limits, pausing (dwelling) at each limit before reversing.
- Replaces hand-driven direction flipping, and supplies sweep status to the rest of the design.

Parameters:
WIDTH, 8, width of counter feedback; must match counter output width
LOW_LIMIT, 0, lower turn-around count
HIGH_LIMIT, 30, upper turn-around count; LOW_LIMIT+1 < HIGH_LIMIT required
DWELL, 4, cycles enable is held low at each limit; DWELL >= 1 required

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  sampled pulse; begins sweeping from IDLE
stop  input  1  sampled pulse; returns to IDLE
counter_in  input  WIDTH  current counter output (feedback)
enable  output  1  to counter enable
direction  output  1  to counter direction; 1 = up, 0 = down
busy  output  1  high in any state other than IDLE
turn  output  1  single-cycle pulse on each reversal
sweep_count  output  8  completed up+down sweeps

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-low. While rst=0: state IDLE, enable=0, direction=1, busy=0, turn=0, sweep_count=0, dwell counter=0. These take effect immediately, with no clock edge needed.
- States and outputs:
  - IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
  - enable is decoded from state: 1 only in UP and DOWN.
  - busy = (state != IDLE).
  - direction and turn are registered.
- IDLE:
  - start=1 and counter_in >= HIGH_LIMIT -> DOWN, direction<=0.
  - Otherwise start=1 -> UP, direction<=1.
  - Without start, direction holds its last value.
- UP: when counter_in == HIGH_LIMIT-1 -> DWELL_HI. On that same edge the counter reaches HIGH_LIMIT and enable drops, so the counter stops exactly at HIGH_LIMIT.
- DWELL_HI:
  - Counts DWELL cycles with enable=0.
  - On the last dwell cycle: -> DOWN, direction<=0, turn<=1 for one cycle.
- DOWN: when counter_in == LOW_LIMIT+1 -> DWELL_LO.
- DWELL_LO:
  - Counts DWELL cycles.
  - On exit: -> UP, direction<=1, turn<=1, sweep_count<=sweep_count+1.
  - sweep_count wraps 255 -> 0.
- Sweep period (defaults): 30+4+30+4 = 68 cycles.
- Priority: stop > limit/dwell transitions > start.
  - stop=1 in any state -> IDLE; dwell counter cleared; direction and sweep_count held.
  - The counter still sees enable=1 on the stop edge if in UP/DOWN, so at most one extra step.
- Ignored inputs:
  - start while busy=1 has no effect.
  - start and stop together in IDLE -> remain IDLE.
- Out-of-range feedback: in UP with counter_in > HIGH_LIMIT, or in DOWN with counter_in < LOW_LIMIT -> enter the matching dwell state immediately; no wrap-around past the limits.
- Restart after stop resumes from the current count and follows the IDLE start rules.

Optional Feature:
- Macro: SWEEP_SINGLE_SHOT_EN.
- Defined: at the end of DWELL_LO, go to IDLE instead of UP. sweep_count still increments and turn still pulses; direction<=1.
- Undefined: sweeping continues until stop or reset.

Test Plan:
- rst=0 asserted between clock edges -> enable=0, direction=1, busy=0, turn=0, sweep_count=0 immediately, with no edge.
- Counter at 0, one-cycle start -> busy=1 and enable=1 after the edge. Counter climbs 0..30 and holds 30 for 4 cycles with enable=0. Then turn pulses once and direction=0.
- Continue -> counter descends 30..0, dwells 4 cycles at 0, sweep_count=1, then UP resumes. Second turn pulse 68 cycles after the first rising-limit turn.
- stop pulse in UP with counter_in=12 -> counter ends at 13, enable=0, busy=0. Subsequent start resumes UP from 13 and reaches 30.
- start+stop together in IDLE -> stays IDLE. start pulse during DOWN -> no change in state or outputs.
- With SWEEP_SINGLE_SHOT_EN defined, full sweep from 0 -> after DWELL_LO: busy=0, sweep_count=1, counter holds 0.
